// File: rtl/clk_div_10mhz.sv
// rtl/clk_div_10mhz.sv - even-ratio clock divider with registered 50% duty output
module clk_div_10mhz #(
    parameter int DIV_RATIO = 10
) (
    input  logic clk_100Mhz,
    input  logic reset,
    output logic clk_10Mhz
);

    // Counter width never drops below one bit, even for the smallest ratio.
    localparam int CNT_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_RATIO - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV_RATIO / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Odd or sub-2 ratios cannot give an exact 50% duty output, so refuse to build.
    generate
        if ((DIV_RATIO < 2) || ((DIV_RATIO % 2) != 0)) begin : g_bad_ratio
            $error("clk_div_10mhz: DIV_RATIO must be even and >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             w_wrap;
    logic             w_toggle;

    // Wrap at the end of a full output period, toggle at each half-period boundary.
    always_comb begin
        w_wrap   = (r_cnt == CNT_MAX);
        w_toggle = w_wrap || (r_cnt == CNT_HALF);
    end

    // Position counter within one output period, 0..DIV_RATIO-1.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Output flop; the divided clock leaves straight from here so it cannot glitch.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            r_clk <= 1'b0;
        end else if (w_toggle) begin
            r_clk <= ~r_clk;
        end
    end

    assign clk_10Mhz = r_clk;

endmodule

// File: tb/tb_clk_div_10mhz.sv
// tb/tb_clk_div_10mhz.sv - scoreboard bench for clk_div_10mhz at ratios 10, 2 and 4
module tb_clk_div_10mhz;

    typedef struct {
        logic [31:0] cnt;
        logic        out;
    } exp_t;

    logic clk_100Mhz = 1'b0;
    logic reset      = 1'b1;
    logic out10;
    logic out2;
    logic out4;

    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q[$];
    int   ratio[3] = '{10, 2, 4};
    int   m_cnt[3];
    logic m_out[3];
    int   run_len[3];
    logic run_prev[3];
    bit   run_started[3];

    always #5 clk_100Mhz = ~clk_100Mhz;

    clk_div_10mhz #(.DIV_RATIO(10)) u_div10 (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .clk_10Mhz  (out10)
    );

    clk_div_10mhz #(.DIV_RATIO(2)) u_div2 (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .clk_10Mhz  (out2)
    );

    clk_div_10mhz #(.DIV_RATIO(4)) u_div4 (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .clk_10Mhz  (out4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One input clock edge: drive reset, predict, then compare after the edge.
    task automatic step(input logic rst);
        exp_t        e;
        logic        obs_out[3];
        logic [31:0] obs_cnt[3];
        bit          tog;
        @(negedge clk_100Mhz);
        reset = rst;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_cnt[i] = 0;
                m_out[i] = 1'b0;
            end else begin
                tog = (m_cnt[i] == ratio[i] / 2 - 1) || (m_cnt[i] == ratio[i] - 1);
                if (tog) m_out[i] = ~m_out[i];
                m_cnt[i] = (m_cnt[i] == ratio[i] - 1) ? 0 : m_cnt[i] + 1;
            end
            e.cnt = m_cnt[i];
            e.out = m_out[i];
            q.push_back(e);
        end
        @(posedge clk_100Mhz);
        #1;
        obs_out[0] = out10;
        obs_out[1] = out2;
        obs_out[2] = out4;
        obs_cnt[0] = 32'(u_div10.r_cnt);
        obs_cnt[1] = 32'(u_div2.r_cnt);
        obs_cnt[2] = 32'(u_div4.r_cnt);
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front();
            chk($sformatf("out_r%0d", ratio[i]), 32'(obs_out[i]), 32'(e.out));
            chk($sformatf("cnt_r%0d", ratio[i]), obs_cnt[i], e.cnt);
            if (rst) begin
                run_started[i] = 1'b0;
                run_len[i]     = 0;
                run_prev[i]    = obs_out[i];
            end else if (obs_out[i] === run_prev[i]) begin
                run_len[i]++;
            end else begin
                if (run_started[i])
                    chk($sformatf("phase_r%0d", ratio[i]), 32'(run_len[i]), 32'(ratio[i] / 2));
                run_started[i] = 1'b1;
                run_len[i]     = 1;
                run_prev[i]    = obs_out[i];
            end
        end
    endtask

    initial begin
        int edges;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]       = 0;
            m_out[i]       = 1'b0;
            run_len[i]     = 0;
            run_prev[i]    = 1'b0;
            run_started[i] = 1'b0;
        end

        repeat (3) step(1'b1);
        chk("reset_out10", 32'(out10), 32'd0);

        // Four periods right after release, then eight more for phase lengths.
        repeat (40) step(1'b0);
        repeat (80) step(1'b0);

        // Reset while the divided clock is high.
        step(1'b1);
        repeat (7) step(1'b0);
        chk("high_before_rst", 32'(out10), 32'd1);
        step(1'b1);
        chk("mid_rst_out", 32'(out10), 32'd0);
        chk("mid_rst_cnt", 32'(u_div10.r_cnt), 32'd0);
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0);
            edges++;
            if (out10 === 1'b1) break;
        end
        chk("rise_after_rst", 32'(edges), 32'd5);

        // Long reset: nothing may toggle.
        for (int k = 0; k < 20; k++) begin
            step(1'b1);
            chk("held_rst_out10", 32'(out10), 32'd0);
        end

        repeat (24) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
